// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } rx_state_e;

    // Flag positions above the data field in a FIFO entry {ferr, perr, data}.
    localparam int PERR_BIT = 0;
    localparam int FERR_BIT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module uart_sync_fifo import uart_pkg::*; #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LW'(DEPTH));
    assign level   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head is held at the last popped entry once the FIFO drains.
    assign dout = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            cnt <= cnt + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled 3-sample voting, run-time parity/stop config and an entry FIFO.
//
// state    | meaning
// IDLE     | line idle, waiting for a low sample on a tick
// START    | start bit; a high vote is treated as a glitch
// DATA     | data bits, LSB first
// PARITY   | parity bit (only when parity was latched on)
// STOP1    | first stop bit
// STOP2    | second stop bit (only when stop2 was latched on)
// BRK_WAIT | break captured, waiting for the line to return high
module uart_rx_fifo import uart_pkg::*; #(
    parameter  int DATA_BITS   = 8,
    parameter  int OVERSAMPLE  = 16,
    parameter  int DIV_W       = 16,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int LVL_W       = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 pclk,
    input  logic                 prstn,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic [LVL_W-1:0]     irq_thresh,
    input  logic                 rx,
    input  logic                 pop,
    input  logic                 ovr_clr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 empty,
    output logic                 full,
    output logic [LVL_W-1:0]     level,
    output logic                 overrun,
    output logic                 uart_irq
);

    localparam int PH_W  = clog2(OVERSAMPLE);
    localparam int BC_W  = clog2(DATA_BITS);
    localparam int ENT_W = DATA_BITS + 2;

    localparam logic [PH_W-1:0] PH_PRE  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_RES  = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;

    rx_state_e              state;
    rx_state_e              state_nxt;
    logic [PH_W-1:0]        phase;
    logic [BC_W-1:0]        bit_cnt;
    logic                   samp_a;
    logic                   samp_b;
    logic [DATA_BITS-1:0]   shreg;
    logic                   pbit_q;
    logic                   stop1_q;
    logic                   par_en_l;
    logic                   par_odd_l;
    logic                   stop2_l;
    logic                   push_q;
    logic [ENT_W-1:0]       push_entry;

    logic                   at_pre;
    logic                   at_mid;
    logic                   at_res;
    logic                   bit_end;
    logic                   vote;
    logic                   final_stop;
    logic                   ferr_c;
    logic                   perr_c;
    logic                   brk_c;
    logic                   start_det;

    logic [ENT_W-1:0]       head;
    logic                   fifo_drop;

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Compare with >= so lowering baud_div below the running count cannot stall the tick.
    assign tick = (div_cnt >= baud_div);

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shreg      <= '0;
            pbit_q     <= 1'b0;
            stop1_q    <= 1'b1;
            par_en_l   <= 1'b0;
            par_odd_l  <= 1'b0;
            stop2_l    <= 1'b0;
            push_q     <= 1'b0;
            push_entry <= '0;
        end else begin
            state  <= state_nxt;
            push_q <= final_stop;
            if (final_stop) begin
                push_entry <= {ferr_c, perr_c, shreg};
            end

            if (state == IDLE || state == BRK_WAIT) begin
                phase <= '0;
            end else if (tick) begin
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end

            if (start_det) begin
                par_en_l  <= parity_en;
                par_odd_l <= parity_odd;
                stop2_l   <= stop2;
                shreg     <= '0;
            end

            if (at_pre) begin
                samp_a <= rx_s;
            end
            if (at_mid) begin
                samp_b <= rx_s;
            end

            if (state == START && bit_end) begin
                bit_cnt <= '0;
            end
            if (state == DATA && at_res) begin
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            end
            if (state == DATA && bit_end) begin
                bit_cnt <= bit_cnt + BC_W'(1);
            end
            if (state == PARITY && at_res) begin
                pbit_q <= vote;
            end
            if (state == STOP1 && at_res) begin
                stop1_q <= vote;
            end
        end
    end

    always_comb begin
        at_pre     = tick && (phase == PH_PRE);
        at_mid     = tick && (phase == PH_MID);
        at_res     = tick && (phase == PH_RES);
        bit_end    = tick && (phase == PH_LAST);
        start_det  = (state == IDLE) && tick && !rx_s;
        vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        final_stop = at_res && (((state == STOP1) && !stop2_l) || (state == STOP2));
        ferr_c     = !vote || ((state == STOP2) && !stop1_q);
        perr_c     = par_en_l && ((^shreg) ^ pbit_q ^ par_odd_l);
        brk_c      = (shreg == '0) && !vote && ((state != STOP2) || !stop1_q)
                     && !(par_en_l && pbit_q);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_res && vote) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == BC_LAST)) begin
                    state_nxt = par_en_l ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP1;
                end
            end
            STOP1: begin
                if (final_stop) begin
                    state_nxt = brk_c ? BRK_WAIT : IDLE;
                end else if (bit_end) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                if (final_stop) begin
                    state_nxt = brk_c ? BRK_WAIT : IDLE;
                end
            end
            BRK_WAIT: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pclk),
        .rst_b (prstn),
        .push  (push_q),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (empty),
        .full  (full),
        .level (level),
        .drop  (fifo_drop)
    );

    assign rd_data = head[DATA_BITS-1:0];
    assign rd_perr = head[DATA_BITS + PERR_BIT];
    assign rd_ferr = head[DATA_BITS + FERR_BIT];

    always_ff @(posedge pclk) begin
        if (!prstn) begin
            overrun  <= 1'b0;
            uart_irq <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
            uart_irq <= overrun || ((irq_thresh != '0) && (level >= irq_thresh));
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner sequences, random frames vs a queue model.
module tb_uart_rx_fifo;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic        pclk;
    logic        prstn;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [2:0]  irq_thresh;
    logic        rx;
    logic        pop;
    logic        ovr_clr;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic        empty;
    logic        full;
    logic [2:0]  level;
    logic        overrun;
    logic        uart_irq;

    uart_rx_fifo #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (OS),
        .DIV_W       (16),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .pclk       (pclk),
        .prstn      (prstn),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .irq_thresh (irq_thresh),
        .rx         (rx),
        .pop        (pop),
        .ovr_clr    (ovr_clr),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .rd_ferr    (rd_ferr),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .overrun    (overrun),
        .uart_irq   (uart_irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       f;
    } ent_t;

    typedef struct {
        logic [7:0] d;
        logic       pon;
        logic       podd;
        logic       pb;
        logic       s2;
        logic [1:0] sv;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t mq[$];
    logic m_ovr;
    int   lat;
    int   lat_meas;
    logic irq_at_lat;
    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Parity error when the total count of ones (data + parity bit) has the wrong oddness.
    function automatic ent_t expect_ent(input logic [7:0] d, input logic pon, input logic podd,
                                        input logic pb, input logic s2, input logic [1:0] sv);
        ent_t e;
        e.d = d;
        e.p = pon && ((($countones(d) + int'(pb)) % 2) != int'(podd));
        e.f = !sv[0] || (s2 && !sv[1]);
        return e;
    endfunction

    task automatic model_push(input ent_t e);
        if (mq.size() == DEPTH) m_ovr = 1'b1;
        else mq.push_back(e);
    endtask

    // kind: 0 none, 1 pop pulse, 2 ovr_clr pulse, 3 toggle parity_odd; applied at cycle strobe_at.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic [1:0] sv,
                              input int strobe_at, input int kind);
        logic b[$];
        int   cpb;
        int   t;
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (parity_en) b.push_back(pb);
        b.push_back(sv[0]);
        if (stop2) b.push_back(sv[1]);
        cpb = OS * (int'(baud_div) + 1);
        t   = 0;
        lat = -1;
        foreach (b[k]) begin
            repeat (cpb) begin
                @(negedge pclk);
                if (lat < 0 && !empty) begin
                    lat        = t;
                    irq_at_lat = uart_irq;
                end
                rx      = b[k];
                pop     = (kind == 1) && (t == strobe_at);
                ovr_clr = (kind == 2) && (t == strobe_at);
                if (kind == 3 && t == strobe_at) parity_odd = ~parity_odd;
                t++;
            end
        end
        @(negedge pclk);
        rx      = 1'b1;
        pop     = 1'b0;
        ovr_clr = 1'b0;
        repeat (2 * cpb) @(negedge pclk);
    endtask

    task automatic check_pop(input string nm);
        @(negedge pclk);
        if (mq.size() == 0) begin
            chk({nm, "_empty"}, empty, 1);
        end else begin
            chk({nm, "_nonempty"}, empty, 0);
            chk({nm, "_data"}, rd_data, mq[0].d);
            chk({nm, "_perr"}, rd_perr, mq[0].p);
            chk({nm, "_ferr"}, rd_ferr, mq[0].f);
            void'(mq.pop_front());
        end
        pop = 1'b1;
        @(negedge pclk);
        pop = 1'b0;
    endtask

    task automatic check_level(input string nm);
        @(negedge pclk);
        chk({nm, "_level"}, level, mq.size());
        chk({nm, "_full"}, full, (mq.size() == DEPTH));
        chk({nm, "_overrun"}, overrun, m_ovr);
    endtask

    task automatic do_reset();
        prstn = 1'b0;
        repeat (2) @(negedge pclk);
        prstn = 1'b1;
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] bd, input logic pon, input logic podd, input logic s2);
        baud_div   = bd;
        parity_en  = pon;
        parity_odd = podd;
        stop2      = s2;
    endtask

    initial begin
        rx = 1'b1; pop = 1'b0; ovr_clr = 1'b0; prstn = 1'b0;
        irq_thresh = '0; m_ovr = 1'b0; lat_meas = 158; irq_at_lat = 1'b0;
        cfg(16'd0, 1'b0, 1'b0, 1'b0);

        vt[0] = '{8'hA5, 0, 0, 0, 0, 2'b11, 8'hA5, 0, 0};
        vt[1] = '{8'h3C, 1, 0, 1, 0, 2'b11, 8'h3C, 1, 0};
        vt[2] = '{8'h3C, 1, 0, 0, 0, 2'b11, 8'h3C, 0, 0};
        vt[3] = '{8'h3C, 1, 1, 1, 0, 2'b11, 8'h3C, 0, 0};
        vt[4] = '{8'h07, 1, 1, 0, 0, 2'b11, 8'h07, 0, 0};
        vt[5] = '{8'h07, 1, 0, 0, 0, 2'b11, 8'h07, 1, 0};
        vt[6] = '{8'h81, 0, 0, 0, 1, 2'b01, 8'h81, 0, 1};
        vt[7] = '{8'h12, 0, 0, 0, 0, 2'b10, 8'h12, 0, 1};
        vt[8] = '{8'h5A, 0, 0, 0, 1, 2'b11, 8'h5A, 0, 0};
        vt[9] = '{8'hFF, 1, 1, 0, 1, 2'b10, 8'hFF, 1, 1};

        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_irq", uart_irq, 0);
        chk("rst_rd", {rd_ferr, rd_perr, rd_data}, 0);
        do_reset();

        // First frame: latency, irq lag, pop
        irq_thresh = 3'd1;
        send_frame(8'hA5, 1'b0, 2'b11, -1, 0);
        if (lat >= 0) lat_meas = lat;
        chk("push_latency_window", (lat >= 152 && lat <= 162), 1);
        chk("irq_lags_level", irq_at_lat, 0);
        @(negedge pclk);
        chk("a5_level", level, 1);
        chk("a5_irq", uart_irq, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_flags", {rd_ferr, rd_perr}, 0);
        pop = 1'b1;
        @(negedge pclk);
        pop = 1'b0;
        chk("a5_pop_empty", empty, 1);
        repeat (2) @(negedge pclk);
        chk("a5_irq_drop", uart_irq, 0);
        chk("a5_hold_data", rd_data, 8'hA5);
        irq_thresh = 3'd0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            cfg(16'(i % 2), vt[i].pon, vt[i].podd, vt[i].s2);
            send_frame(vt[i].d, vt[i].pb, vt[i].sv, -1, 0);
            @(negedge pclk);
            chk($sformatf("vec%0d_level", i), level, 1);
            chk($sformatf("vec%0d_data", i), rd_data, vt[i].ed);
            chk($sformatf("vec%0d_perr", i), rd_perr, vt[i].ep);
            chk($sformatf("vec%0d_ferr", i), rd_ferr, vt[i].ef);
            pop = 1'b1;
            @(negedge pclk);
            pop = 1'b0;
            @(negedge pclk);
            chk($sformatf("vec%0d_drained", i), empty, 1);
        end

        // Parity config changed mid-frame has no effect
        cfg(16'd0, 1'b1, 1'b0, 1'b0);
        model_push(expect_ent(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11));
        send_frame(8'h3C, 1'b1, 2'b11, 40, 3);
        parity_odd = 1'b0;
        check_pop("latch_cfg");

        // Start-bit glitch rejected
        cfg(16'd0, 1'b0, 1'b0, 1'b0);
        repeat (5) begin @(negedge pclk); rx = 1'b0; end
        @(negedge pclk); rx = 1'b1;
        repeat (64) @(negedge pclk);
        chk("glitch_level", level, 0);
        chk("glitch_empty", empty, 1);
        model_push(expect_ent(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'h5A, 1'b0, 2'b11, -1, 0);
        check_pop("after_glitch");

        // Overrun, ovr_clr vs new overrun, pop coincident with push when full
        foreach (vt[i]) if (i < 5) begin
            model_push(expect_ent(8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
            send_frame(8'(8'h11 * (i + 1)), 1'b0, 2'b11, -1, 0);
        end
        check_level("ovr");
        chk("ovr_irq", uart_irq, 1);
        @(negedge pclk); ovr_clr = 1'b1;
        @(negedge pclk); ovr_clr = 1'b0; m_ovr = 1'b0;
        check_level("ovr_clr");
        model_push(expect_ent(8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'h66, 1'b0, 2'b11, lat_meas - 1, 2);
        check_level("clr_and_new_ovr");
        @(negedge pclk); ovr_clr = 1'b1;
        @(negedge pclk); ovr_clr = 1'b0; m_ovr = 1'b0;
        repeat (2) @(negedge pclk);
        chk("ovr_clr_irq", uart_irq, 0);
        void'(mq.pop_front());
        model_push(expect_ent(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'h77, 1'b0, 2'b11, lat_meas - 1, 1);
        check_level("push_pop_full");
        repeat (5) check_pop("drain_order");

        // Break: one entry, then normal frame
        repeat (400) begin @(negedge pclk); rx = 1'b0; end
        @(negedge pclk); rx = 1'b1;
        repeat (64) @(negedge pclk);
        chk("brk_level", level, 1);
        chk("brk_data", rd_data, 0);
        chk("brk_ferr", rd_ferr, 1);
        chk("brk_perr", rd_perr, 0);
        pop = 1'b1; @(negedge pclk); pop = 1'b0;
        repeat (40) @(negedge pclk);
        chk("brk_single", empty, 1);
        model_push(expect_ent(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'hC3, 1'b0, 2'b11, -1, 0);
        check_pop("after_brk");

        // Reset in the middle of a frame
        irq_thresh = 3'd1;
        model_push(expect_ent(8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'h44, 1'b0, 2'b11, -1, 0);
        chk("pre_rst_irq", uart_irq, 1);
        foreach (vt[i]) if (i < 4) begin
            repeat (OS) begin @(negedge pclk); rx = (i == 1); end
        end
        repeat (OS / 2) begin @(negedge pclk); rx = 1'b0; end
        rx = 1'b1;
        do_reset();
        repeat (48) @(negedge pclk);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_irq", uart_irq, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_rd", rd_data, 0);
        model_push(expect_ent(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
        send_frame(8'h81, 1'b0, 2'b11, -1, 0);
        check_pop("after_mid_rst");
        irq_thresh = 3'd0;

        // Randomised frames against the queue model
        for (int r = 0; r < 6; r++) begin
            int nf;
            nf = $urandom_range(1, DEPTH);
            for (int f = 0; f < nf; f++) begin
                logic [7:0] d;
                logic       pb;
                logic [1:0] sv;
                d  = 8'($urandom);
                pb = 1'($urandom);
                sv = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
                cfg(16'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom));
                model_push(expect_ent(d, parity_en, parity_odd, pb, stop2, sv));
                send_frame(d, pb, sv, -1, 0);
                check_level($sformatf("rnd%0d_%0d", r, f));
            end
            for (int f = 0; f < nf; f++) check_pop($sformatf("rnd%0d_pop", r));
        end
        @(negedge pclk);
        chk("final_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
